// File: rtl/aes_pkg.sv
// Shared definitions for the AES round sequencer: stage indices, FSM states
// and round counts per key size.
package aes_pkg;

    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned NR_AES192 = 12;
    localparam int unsigned NR_AES256 = 14;

    typedef logic [1:0] stage_t;

    // Bit positions inside the 4-bit stage vectors {ark, mc, sr, sb}.
    localparam stage_t SB  = 2'd0;
    localparam stage_t SR  = 2'd1;
    localparam stage_t MC  = 2'd2;
    localparam stage_t ARK = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StClr,
        StRun,
        StFin
    } state_e;

    function automatic logic [3:0] stage_onehot(input stage_t s);
        stage_onehot = 4'b0001 << s;
    endfunction

endpackage

// File: rtl/stage_timer.sv
// Per-stage watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the TMO-th enabled cycle is being spent.
module stage_timer #(
    parameter int unsigned TMO = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TMO + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CW'(TMO))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == CW'(TMO - 1));

endmodule

// File: rtl/aes_round_seq.sv
// AES round sequencer: walks the SB/SR/MC/ARK stages through NR rounds with a
// clear/run handshake per stage and a per-stage timeout.
module aes_round_seq
    import aes_pkg::*;
#(
    parameter int unsigned NR  = 10,
    parameter int unsigned TMO = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] stg_done,
    output logic [3:0] stg_en,
    output logic [3:0] stg_clr,
    output logic       load_pt,
    output logic [3:0] round_idx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] LastRound = 4'(NR);

    state_e     state_q, state_d;
    stage_t     stage_q, stage_d;
    logic [3:0] round_q, round_d;
    logic       err_d;
    logic       tmo_expired;

    stage_timer #(
        .TMO(TMO)
    ) u_stage_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == StClr),
        .enable (state_q == StRun),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        round_d = round_q;
        err_d   = err;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClr;
                    stage_d = ARK;
                    round_d = '0;
                    err_d   = 1'b0;
                end
            end
            StClr: begin
                state_d = StRun;
            end
            StRun: begin
                if (stg_done[stage_q]) begin
                    unique case (stage_q)
                        SB: begin
                            stage_d = SR;
                            state_d = StClr;
                        end
                        SR: begin
                            // The final round has no MixColumns.
                            stage_d = (round_q == LastRound) ? ARK : MC;
                            state_d = StClr;
                        end
                        MC: begin
                            stage_d = ARK;
                            state_d = StClr;
                        end
                        ARK: begin
                            if (round_q == LastRound) begin
                                state_d = StFin;
                            end else begin
                                round_d = round_q + 4'd1;
                                stage_d = SB;
                                state_d = StClr;
                            end
                        end
                    endcase
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are plain flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            stage_q <= ARK;
            round_q <= '0;
            stg_en  <= '0;
            stg_clr <= '0;
            load_pt <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            round_q <= round_d;
            stg_en  <= (state_d == StRun) ? stage_onehot(stage_d) : 4'b0000;
            stg_clr <= (state_d == StClr) ? stage_onehot(stage_d) : 4'b0000;
            load_pt <= ((state_d == StClr) || (state_d == StRun)) &&
                       (round_d == 4'd0) && (stage_d == ARK);
            busy    <= (state_d != StIdle);
            done    <= (state_d == StFin);
            err     <= err_d;
        end
    end

    assign round_idx = round_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq: table of stage-latency scenarios checked against a
// stage-sequence scoreboard, plus reset and held-start sequences.
module tb_aes_round_seq;

    localparam int NR  = 10;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] stg_done;
    logic [3:0] stg_en;
    logic [3:0] stg_clr;
    logic       load_pt;
    logic [3:0] round_idx;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    aes_round_seq #(
        .NR (NR),
        .TMO(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stg_done (stg_done),
        .stg_en   (stg_en),
        .stg_clr  (stg_clr),
        .load_pt  (load_pt),
        .round_idx(round_idx),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        int round;
        int stage;
    } step_t;

    typedef struct {
        string name;
        int    dr;   // round of the slowed stage (-1: none)
        int    ds;   // stage index of the slowed stage (-1: none)
        int    dc;   // cycles it holds done low+1; 0 means never done
        int    lat;  // edges from start to done/err
        bit    e;
    } vec_t;

    step_t exp_q[$];
    vec_t  vecs[7];

    int n_checks = 0;
    int n_fail   = 0;

    int sc_round  = -1;
    int sc_stage  = -1;
    int sc_cycles = 1;
    int hold_len  = 0;

    int         cnt[4];
    logic [3:0] noise = 4'b0000;
    logic [3:0] prev_en = 4'b0000;
    logic [3:0] prev_clr = 4'b0000;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [3:0] oh(input int s);
        logic [3:0] one;
        one = 4'b0001;
        return one << s;
    endfunction

    // Stage model: done follows enable after the scenario's latency; unrelated
    // bits carry random noise that the sequencer must ignore.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (stg_clr[i]) cnt[i] <= 0;
            else if (stg_en[i]) cnt[i] <= cnt[i] + 1;
        end
        noise <= 4'($urandom);
    end

    always_comb begin
        stg_done = noise & ~stg_en;
        for (int i = 0; i < 4; i++) begin
            if (stg_en[i]) begin
                if (int'(round_idx) == sc_round && i == sc_stage) begin
                    if (sc_cycles != 0 && cnt[i] >= sc_cycles - 1) stg_done[i] = 1'b1;
                end else begin
                    stg_done[i] = 1'b1;
                end
            end
        end
    end

    // Scoreboard consumer: each entry into a RUN phase pops one expected step.
    always @(negedge clk) begin
        if (stg_en != 4'b0000 && prev_en == 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_run", int'(stg_en), 0);
            end else begin
                step_t e;
                e = exp_q.pop_front();
                check("run_round", int'(round_idx), e.round);
                check("run_stage_en", int'(stg_en), int'(oh(e.stage)));
                check("clr_before_run", int'(prev_clr), int'(oh(e.stage)));
                check("run_load_pt", int'(load_pt), int'(e.round == 0 && e.stage == 3));
            end
        end
        if (busy && int'(round_idx) == NR) check("no_mc_final", int'(stg_en[2]), 0);
        if (sc_stage >= 0 && stg_en == oh(sc_stage) && int'(round_idx) == sc_round)
            hold_len <= hold_len + 1;
        prev_en  <= stg_en;
        prev_clr <= stg_clr;
    end

    task automatic push_seq(input int dr, input int ds, input int dc);
        for (int r = 0; r <= NR; r++) begin
            for (int s = 0; s < 4; s++) begin
                if (r == 0 && s != 3) continue;
                if (r == NR && s == 2) continue;
                exp_q.push_back('{round: r, stage: s});
                if (r == dr && s == ds && dc == 0) return;
            end
        end
    endtask

    task automatic do_txn(input string name, input int dr, input int ds, input int dc,
                          input int lat, input bit exp_err);
        int n;
        bit seen;
        sc_round  = dr;
        sc_stage  = ds;
        sc_cycles = dc;
        hold_len  = 0;
        push_seq(dr, ds, dc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n    = 1;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check({name, "_start_err"}, int'(err), 0);
        check({name, "_start_busy"}, int'(busy), 1);
        check({name, "_start_clr"}, int'(stg_clr), int'(oh(3)));
        check({name, "_start_ldpt"}, int'(load_pt), 1);
        while (!seen && n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done || err) seen = 1'b1;
        end
        check({name, "_finished"}, int'(seen), 1);
        check({name, "_latency"}, n, lat);
        check({name, "_err"}, int'(err), int'(exp_err));
        check({name, "_done"}, int'(done), int'(!exp_err));
        check({name, "_busy_end"}, int'(busy), int'(!exp_err));
        if (ds >= 0) check({name, "_hold"}, hold_len, (dc == 0) ? TMO : dc);
        @(negedge clk);
        check({name, "_done_pulse"}, int'(done), 0);
        check({name, "_idle_busy"}, int'(busy), 0);
        check({name, "_err_sticky"}, int'(err), int'(exp_err));
        if (!exp_err) check({name, "_round_hold"}, int'(round_idx), NR);
        check({name, "_sb_empty"}, exp_q.size(), 0);
        exp_q.delete();
        sc_stage = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d1;
        int d2;
        bit found;

        vecs[0] = '{name: "nominal",  dr: -1, ds: -1, dc: 1, lat: 81, e: 1'b0};
        vecs[1] = '{name: "mc_r3_5",  dr: 3,  ds: 2,  dc: 5, lat: 85, e: 1'b0};
        vecs[2] = '{name: "sb_r1_3",  dr: 1,  ds: 0,  dc: 3, lat: 83, e: 1'b0};
        vecs[3] = '{name: "ark_r0_2", dr: 0,  ds: 3,  dc: 2, lat: 82, e: 1'b0};
        vecs[4] = '{name: "ark_rN_4", dr: 10, ds: 3,  dc: 4, lat: 84, e: 1'b0};
        vecs[5] = '{name: "mc_hang",  dr: 1,  ds: 2,  dc: 0, lat: 72, e: 1'b1};
        vecs[6] = '{name: "post_tmo", dr: -1, ds: -1, dc: 1, lat: 81, e: 1'b0};

        // Reset held with start high: reset must win.
        rst   = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_en", int'(stg_en), 0);
        check("rst_clr", int'(stg_clr), 0);
        check("rst_ldpt", int'(load_pt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_round", int'(round_idx), 0);
        start = 1'b0;
        rst   = 1'b0;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 7; v++) begin
            do_txn(vecs[v].name, vecs[v].dr, vecs[v].ds, vecs[v].dc, vecs[v].lat, vecs[v].e);
        end

        // Reset in the middle of round 4 ShiftRows.
        push_seq(-1, -1, 1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (int'(round_idx) == 4 && stg_en == oh(1)) found = 1'b1;
        end
        check("midrst_reached", int'(found), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_en", int'(stg_en), 0);
        check("midrst_clr", int'(stg_clr), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ldpt", int'(load_pt), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_round", int'(round_idx), 0);
        exp_q.delete();
        do_txn("after_rst", -1, -1, 1, 81, 1'b0);

        // Start held high across done: exactly one back-to-back restart.
        push_seq(-1, -1, 1);
        push_seq(-1, -1, 1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n  = 1;
        d1 = 0;
        d2 = 0;
        while (d2 == 0 && n < 400) begin
            @(negedge clk);
            if (done) begin
                if (d1 == 0) begin
                    d1 = n;
                end else begin
                    d2    = n;
                    start = 1'b0;
                end
            end
            if (d2 == 0) begin
                @(posedge clk);
                n++;
            end
        end
        start = 1'b0;
        check("hold_first_done", d1, 81);
        check("hold_gap", d2 - d1, 82);
        repeat (4) @(negedge clk);
        check("hold_idle_busy", int'(busy), 0);
        check("hold_sb_empty", exp_q.size(), 0);
        exp_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_seq.md
AES_ROUND_SEQ -- requirements
Module: aes_round_seq

Interface
REQ-001 Parameter NR, default 10, number of AES rounds (10/12/14 allowed).
REQ-002 Parameter TMO, default 64, max cycles a stage may take before timeout.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin one block encryption; sampled only in IDLE.
REQ-006 stg_done  input  4  per-stage done level, bit order {ark, mc, sr, sb}.
REQ-007 stg_en  output  4  per-stage enable, same bit order; at most one bit high.
REQ-008 stg_clr  output  4  per-stage one-cycle clear (drives stage rst), same bit order.
REQ-009 load_pt  output  1  selects plaintext (not round output) into the state register for round 0.
REQ-010 round_idx  output  4  current round 0..NR; selects the round key.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when the ciphertext is valid.
REQ-013 err  output  1  sticky timeout flag.

Function
REQ-014 FSM states: IDLE, CLR, RUN, FIN; register stage ∈ {SB, SR, MC, ARK}.
REQ-015 IDLE + start=1 -> CLR with stage=ARK, round_idx=0, err cleared; start ignored in other states.
REQ-016 CLR: stg_clr[stage]=1 for exactly one cycle, stg_en=0; next state RUN, timeout counter cleared.
REQ-017 RUN: stg_en[stage]=1 held until stg_done[stage]=1 sampled; on that edge stg_en drops next cycle.
REQ-018 Stage order per round r: r=0 ARK only; 1<=r<NR: SB, SR, MC, ARK; r=NR: SB, SR, ARK (MC skipped).
REQ-019 round_idx increments by 1 when leaving ARK with round_idx<NR; after ARK with round_idx=NR -> FIN.
REQ-020 load_pt=1 only while round_idx=0 and stage=ARK (CLR and RUN).
REQ-021 FIN: done=1 for one cycle, then IDLE; round_idx holds NR until the next start.
REQ-022 stg_done bits other than stg_done[stage] are ignored.
REQ-023 stg_done[stage] already high on the first RUN cycle counts as completion (clear guarantees freshness).
REQ-024 Timeout: counter increments each RUN cycle; if TMO cycles pass without done -> err=1, stg_en=0, IDLE, no done pulse.
REQ-025 err stays high until the next accepted start or rst.
REQ-026 Latency per stage = 1 (CLR) + stage RUN cycles; single-cycle stages give 2 cycles/stage, total 2*(1+4*(NR-1)+3)+1 cycles from start to done (81 for NR=10).
REQ-027 Timeout counter width = clog2(TMO+1); no wrap before comparison.

Reset
REQ-028 rst=1 at any time, including mid-round: next state IDLE, stage=ARK, round_idx=0.
REQ-029 Reset values: stg_en=0, stg_clr=0, load_pt=0, busy=0, done=0, err=0.
REQ-030 rst has priority over start and stg_done in the same cycle.

Structure
REQ-031 Shared package aes_pkg holds the stage-index constants (SB=0, SR=1, MC=2, ARK=3), the state enum, and NR defaults per key size.
REQ-032 Single module; the timeout counter is a separate sub-module, stage_timer (clear, enable, expired).
REQ-033 Outputs are registered; no combinational path from stg_done to stg_en.

Verification
REQ-034 start pulse, stages with 1-cycle done -> stage sequence ARK, then (SB, SR, MC, ARK)x9, then SB, SR, ARK; done at cycle 81; round_idx 0..10.
REQ-035 NR=10, final round -> stg_en[MC] never asserted while round_idx=10.
REQ-036 MC stage done delayed 5 cycles in round 3 -> stg_en[2] held 5 cycles, total latency 85.
REQ-037 stg_done[MC] never asserted, TMO=64 -> err=1 after 64 RUN cycles, busy=0, no done pulse; next start clears err.
REQ-038 rst asserted during round 4 SR -> next cycle IDLE, all outputs 0; a new start runs a full correct 81-cycle sequence.
REQ-039 start held high through done -> exactly one new encryption begins on the cycle after FIN returns to IDLE; start pulses while busy have no effect.
